// File: rtl/fft_stream_pkg.sv
// Shared types for the FIFO<->FFT streamers.
// State encoding, FFT exponent width and Avalon-ST beat layout.
package fft_stream_pkg;

  localparam int FFT_EXP_W = 6;
  localparam int BEAT_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [BEAT_W-1:0] re;
    logic [BEAT_W-1:0] im;
    logic              sop;
    logic              eop;
  } beat_t;

endpackage

// File: rtl/fft_frame_streamer.sv
// Pops PCM words from a show-ahead FIFO and emits whole Avalon-ST FFT
// packets (mono or stereo-packed), with backpressure and zero-pad abort.
// Ports:
//   fifo_q/fifo_usedw/fifo_rdreq : FIFO read side
//   src_*                        : Avalon-ST source into FFT sink
//   exp_in/exp_strobe/exp_out    : FFT block-exponent latch
//   enable/abort/busy/frame_cnt  : control and status
module fft_frame_streamer
  import fft_stream_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int OUT_W     = 16,
  parameter int FRAME_LEN = 4096,
  parameter int STEREO    = 0,
  parameter int CNT_W     = 14
) (
  input  logic                 fft_clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 abort,
  input  logic [DATA_W-1:0]    fifo_q,
  input  logic [CNT_W-1:0]     fifo_usedw,
  output logic                 fifo_rdreq,
  input  logic                 src_ready,
  output logic                 src_valid,
  output logic                 src_sop,
  output logic                 src_eop,
  output logic [OUT_W-1:0]     src_real,
  output logic [OUT_W-1:0]     src_imag,
  input  logic [FFT_EXP_W-1:0] exp_in,
  input  logic                 exp_strobe,
  output logic [FFT_EXP_W-1:0] exp_out,
  output logic                 busy,
  output logic [15:0]          frame_cnt
);

  localparam int NEED = FRAME_LEN * (1 + STEREO);
  localparam int PW   = $clog2(FRAME_LEN);
  localparam logic [PW-1:0] LAST = PW'(FRAME_LEN - 1);

  state_e               state_q, state_d;
  logic [PW-1:0]        pos_q, pos_d;
  logic                 phase_q, phase_d;
  logic [DATA_W-1:0]    hold_q, hold_d;
  logic                 valid_q, valid_d;
  logic                 sop_q, sop_d;
  logic                 eop_q, eop_d;
  logic [OUT_W-1:0]     re_q, re_d;
  logic [OUT_W-1:0]     im_q, im_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [FFT_EXP_W-1:0] exp_q, exp_d;

  logic             rdreq, load, room, last;
  logic             eop_pend, eop_acc;
  logic [OUT_W-1:0] ld_re, ld_im;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    phase_d  = phase_q;
    hold_d   = hold_q;
    valid_d  = valid_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    re_d     = re_q;
    im_d     = im_q;
    cnt_d    = cnt_q;
    exp_d    = exp_strobe ? exp_in : exp_q;
    rdreq    = 1'b0;
    load     = 1'b0;
    ld_re    = '0;
    ld_im    = '0;
    eop_pend = valid_q && eop_q;
    eop_acc  = eop_pend && src_ready;
    // A loaded eop waits for acceptance; nothing else may load.
    room     = (!valid_q || src_ready) && !eop_pend;
    last     = (pos_q == LAST);

    if (valid_q && src_ready) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && fifo_usedw >= CNT_W'(NEED)) begin
          state_d = FILL;
          pos_d   = '0;
          phase_d = 1'b0;
        end
      end
      FILL: begin
        // Abort is overridden only by the eop load itself.
        if (STEREO == 0) begin
          if (room && !(abort && !last)) begin
            rdreq = 1'b1;
            load  = 1'b1;
            ld_re = OUT_W'($signed(fifo_q));
          end
        end else if (!phase_q) begin
          if (room && !abort) begin
            rdreq   = 1'b1;
            hold_d  = fifo_q;
            phase_d = 1'b1;
          end
        end else if (room && !(abort && !last)) begin
          rdreq   = 1'b1;
          load    = 1'b1;
          phase_d = 1'b0;
          ld_re   = OUT_W'($signed(hold_q));
          ld_im   = OUT_W'($signed(fifo_q));
        end
        if (abort && !eop_pend && !load) begin
          state_d = PAD;
          phase_d = 1'b0;
        end
      end
      PAD: begin
        if (room) load = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      valid_d = 1'b1;
      sop_d   = (pos_q == '0);
      eop_d   = last;
      re_d    = ld_re;
      im_d    = ld_im;
      pos_d   = pos_q + 1'b1;
    end

    if (eop_acc) begin
      state_d = IDLE;
      cnt_d   = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge fft_clk) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q   <= '0;
      phase_q <= 1'b0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      re_q    <= re_d;
      im_q    <= im_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
    end
  end

  assign fifo_rdreq = rdreq;
  assign src_valid  = valid_q;
  assign src_sop    = sop_q;
  assign src_eop    = eop_q;
  assign src_real   = re_q;
  assign src_imag   = im_q;
  assign exp_out    = exp_q;
  assign busy       = (state_q != IDLE);
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Directed bench: mono FRAME_LEN=8 and stereo FRAME_LEN=4 instances.
// Each instance is fed by a small show-ahead FIFO model.
module tb_fft_frame_streamer;
  import fft_stream_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // mono instance signals
  logic        m_en, m_abort, m_rd, m_ready;
  logic [15:0] m_q;
  logic [13:0] m_usedw;
  logic        m_valid, m_sop, m_eop, m_busy;
  logic [15:0] m_re, m_im, m_cnt;
  logic [5:0]  m_exp_in, m_exp_out;
  logic        m_exp_stb;

  // stereo instance signals
  logic        s_en, s_abort, s_rd, s_ready;
  logic [15:0] s_q;
  logic [13:0] s_usedw;
  logic        s_valid, s_sop, s_eop, s_busy;
  logic [15:0] s_re, s_im, s_cnt;
  logic [5:0]  s_exp_in, s_exp_out;
  logic        s_exp_stb;

  fft_frame_streamer #(
    .DATA_W(16), .OUT_W(16), .FRAME_LEN(8),
    .STEREO(0), .CNT_W(14)
  ) u_mono (
    .fft_clk(clk), .reset(reset),
    .enable(m_en), .abort(m_abort),
    .fifo_q(m_q), .fifo_usedw(m_usedw),
    .fifo_rdreq(m_rd), .src_ready(m_ready),
    .src_valid(m_valid), .src_sop(m_sop),
    .src_eop(m_eop), .src_real(m_re),
    .src_imag(m_im), .exp_in(m_exp_in),
    .exp_strobe(m_exp_stb), .exp_out(m_exp_out),
    .busy(m_busy), .frame_cnt(m_cnt)
  );

  fft_frame_streamer #(
    .DATA_W(16), .OUT_W(16), .FRAME_LEN(4),
    .STEREO(1), .CNT_W(14)
  ) u_stereo (
    .fft_clk(clk), .reset(reset),
    .enable(s_en), .abort(s_abort),
    .fifo_q(s_q), .fifo_usedw(s_usedw),
    .fifo_rdreq(s_rd), .src_ready(s_ready),
    .src_valid(s_valid), .src_sop(s_sop),
    .src_eop(s_eop), .src_real(s_re),
    .src_imag(s_im), .exp_in(s_exp_in),
    .exp_strobe(s_exp_stb), .exp_out(s_exp_out),
    .busy(s_busy), .frame_cnt(s_cnt)
  );

  // FIFO models
  logic [15:0] mmem [0:63];
  logic [15:0] smem [0:63];
  int mwp = 0, mrp = 0, swp = 0, srp = 0;

  assign m_q     = mmem[mrp[5:0]];
  assign s_q     = smem[srp[5:0]];
  assign m_usedw = 14'(mwp - mrp);
  assign s_usedw = 14'(swp - srp);

  always @(posedge clk) begin
    if (m_rd) mrp <= mrp + 1;
    if (s_rd) srp <= srp + 1;
  end

  // observation logs
  beat_t mlog [0:63];
  beat_t slog [0:63];
  int    scyc [0:63];
  int mnb = 0, snb = 0, mpops = 0, spops = 0;
  int mbusy = 0, cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (m_rd) mpops <= mpops + 1;
    if (s_rd) spops <= spops + 1;
    if (m_busy) mbusy <= mbusy + 1;
    if (m_valid && m_ready && mnb < 64) begin
      mlog[mnb] <= '{re: m_re, im: m_im,
                     sop: m_sop, eop: m_eop};
      mnb <= mnb + 1;
    end
    if (s_valid && s_ready && snb < 64) begin
      slog[snb] <= '{re: s_re, im: s_im,
                     sop: s_sop, eop: s_eop};
      scyc[snb] <= cyc;
      snb <= snb + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic mpush(input logic [15:0] v);
    mmem[mwp[5:0]] = v;
    mwp++;
  endtask

  task automatic spush(input logic [15:0] v);
    smem[swp[5:0]] = v;
    swp++;
  endtask

  task automatic m_wait_cnt(input logic [15:0] tgt,
                            input string tag);
    int n = 0;
    while (m_cnt !== tgt && n < 60) begin
      step();
      n++;
    end
    step();
    chk(tag, m_cnt, tgt);
  endtask

  task automatic m_pulse_en();
    m_en = 1'b1;
    step();
    m_en = 1'b0;
  endtask

  // check n accepted mono beats from base hold ramp first..
  task automatic m_chk_ramp(input int base, input int first,
                            input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk(tag, mlog[base+i].re, 32'(first + i));
    end
  endtask

  logic [7:0] v8, w8;
  logic [3:0] v4, w4;
  int b0, p0, bz0, pp;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    m_en = 0; m_abort = 0; m_ready = 1;
    m_exp_in = 0; m_exp_stb = 0;
    s_en = 0; s_abort = 0; s_ready = 1;
    s_exp_in = 0; s_exp_stb = 0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // reset state
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_cnt", m_cnt, 0);
    chk("rst_exp", m_exp_out, 0);
    chk("rst_rd", m_rd, 0);
    chk("rst_s_valid", s_valid, 0);

    // 1: mono ramp 1..8
    for (int i = 1; i <= 8; i++) mpush(16'(i));
    b0 = mnb; p0 = mpops; bz0 = mbusy;
    m_pulse_en();
    m_wait_cnt(16'd1, "t1_cnt");
    chk("t1_nbeats", 32'(mnb - b0), 8);
    m_chk_ramp(b0, 1, 8, "t1_data");
    v8 = '0; w8 = '0;
    for (int i = 0; i < 8; i++) begin
      v8[i] = mlog[b0+i].sop;
      w8[i] = mlog[b0+i].eop;
    end
    chk("t1_sop", v8, 8'h01);
    chk("t1_eop", w8, 8'h80);
    chk("t1_imag", mlog[b0+3].im, 0);
    chk("t1_pops", 32'(mpops - p0), 8);
    chk("t1_busy", 32'(mbusy - bz0), 9);

    // 2: start waits for a whole frame
    for (int i = 11; i <= 17; i++) mpush(16'(i));
    b0 = mnb; p0 = mpops;
    m_en = 1'b1;
    repeat (4) step();
    chk("t2_nopop", 32'(mpops - p0), 0);
    chk("t2_novalid", m_valid, 0);
    chk("t2_idle", m_busy, 0);
    mpush(16'd18);
    step();
    chk("t2_start", m_busy, 1);
    chk("t2_rd", m_rd, 1);
    m_en = 1'b0;
    m_wait_cnt(16'd2, "t2_cnt");
    chk("t2_nbeats", 32'(mnb - b0), 8);
    m_chk_ramp(b0, 11, 8, "t2_data");

    // 3: stereo, L=-1 R=2
    for (int i = 0; i < 4; i++) begin
      spush(16'hFFFF);
      spush(16'h0002);
    end
    b0 = snb; p0 = spops;
    s_en = 1'b1;
    step();
    s_en = 1'b0;
    for (int n = 0; n < 40 && s_cnt !== 16'd1; n++) step();
    step();
    chk("t3_cnt", s_cnt, 1);
    chk("t3_nbeats", 32'(snb - b0), 4);
    chk("t3_pops", 32'(spops - p0), 8);
    v4 = '0; w4 = '0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_real", slog[b0+i].re, 16'hFFFF);
      chk("t3_imag", slog[b0+i].im, 16'h0002);
      v4[i] = slog[b0+i].sop;
      w4[i] = slog[b0+i].eop;
    end
    for (int i = 1; i < 4; i++) begin
      chk("t3_rate", 32'(scyc[b0+i] - scyc[b0+i-1]), 2);
    end
    chk("t3_sop", v4, 4'b0001);
    chk("t3_eop", w4, 4'b1000);

    // 4: backpressure on beat 3
    for (int i = 21; i <= 28; i++) mpush(16'(i));
    b0 = mnb;
    m_pulse_en();
    for (int n = 0; n < 20; n++) begin
      if (m_valid && m_re == 16'd23) break;
      step();
    end
    chk("t4_reach", m_re, 23);
    m_ready = 1'b0;
    pp = mpops;
    repeat (5) begin
      step();
      chk("t4_hold", {m_valid, m_rd, m_re}, {2'b10, 16'd23});
    end
    chk("t4_nopop", 32'(mpops - pp), 0);
    m_ready = 1'b1;
    m_wait_cnt(16'd3, "t4_cnt");
    chk("t4_nbeats", 32'(mnb - b0), 8);
    m_chk_ramp(b0, 21, 8, "t4_data");

    // 5: abort after three loads
    for (int i = 31; i <= 38; i++) mpush(16'(i));
    b0 = mnb; p0 = mpops;
    m_pulse_en();
    repeat (3) step();
    m_abort = 1'b1;
    step();
    m_abort = 1'b0;
    m_wait_cnt(16'd4, "t5_cnt");
    chk("t5_pops", 32'(mpops - p0), 3);
    chk("t5_nbeats", 32'(mnb - b0), 8);
    m_chk_ramp(b0, 31, 3, "t5_data");
    w8 = '0; v8 = '0;
    for (int i = 3; i < 8; i++) begin
      chk("t5_zero", {mlog[b0+i].re, mlog[b0+i].im}, 0);
    end
    for (int i = 0; i < 8; i++) begin
      v8[i] = mlog[b0+i].sop;
      w8[i] = mlog[b0+i].eop;
    end
    chk("t5_sop", v8, 8'h01);
    chk("t5_eop", w8, 8'h80);
    mwp = mrp;

    // abort while idle is ignored
    m_abort = 1'b1;
    repeat (2) step();
    m_abort = 1'b0;
    chk("idle_abort", {m_busy, m_valid}, 0);

    // 6: reset mid-frame, then exponent latch
    for (int i = 41; i <= 48; i++) mpush(16'(i));
    m_pulse_en();
    for (int n = 0; n < 20; n++) begin
      if (m_valid && m_re == 16'd45) break;
      step();
    end
    chk("t6_reach", m_re, 45);
    reset = 1'b1;
    step();
    chk("t6_valid", m_valid, 0);
    chk("t6_busy", m_busy, 0);
    chk("t6_cnt", m_cnt, 0);
    chk("t6_rd", m_rd, 0);
    reset = 1'b0;
    mwp = mrp;
    m_exp_in = 6'd7;
    m_exp_stb = 1'b1;
    step();
    chk("t6_exp", m_exp_out, 7);
    m_exp_stb = 1'b0;
    m_exp_in = 6'd3;
    step();
    chk("t6_exp_hold", m_exp_out, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
